// File: rtl/coeff_bank.sv
// -----------------------------------------------------------------------------
// coeff_bank
//
// Double-buffered coefficient store between the allophone controller and the
// serial filter datapath. Each burst of NCOEFF signed 8-bit coefficients
// (F/B pairs) is collected into the shadow bank. The shadow bank is swapped into
// the active bank only at a pitch-period boundary, so the filter never sees a
// half-updated set. The filter reads the active bank through a registered
// random-access port.
//
// Ports
//   clk            : clock
//   rst_an         : asynchronous reset, active low
//   coeff_in       : signed coefficient, valid while coeff_stb is high
//   coeff_stb      : one coefficient per high cycle
//   period_done_in : one-cycle pulse at the end of a pitch period (commit point)
//   coeff_addr     : filter read address
//   coeff_rd       : active-bank coefficient at coeff_addr, one cycle later
//   coeff_valid    : sticky, set by the first commit
//   set_pending    : a complete set is waiting in the shadow bank
//   commit_stb     : one-cycle pulse on the cycle after a bank swap
//   set_drop       : one-cycle pulse when a partial set is discarded
// -----------------------------------------------------------------------------
module coeff_bank #(
   parameter int NCOEFF      = 12,
   parameter int GAP_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_an,
   input  logic [7:0] coeff_in,
   input  logic       coeff_stb,
   input  logic       period_done_in,
   input  logic [3:0] coeff_addr,
   output logic [7:0] coeff_rd,
   output logic       coeff_valid,
   output logic       set_pending,
   output logic       commit_stb,
   output logic       set_drop
);

   localparam logic [3:0] LAST_IDX   = 4'(NCOEFF - 1);
   localparam logic [3:0] ADDR_LIMIT = 4'(NCOEFF);
   localparam logic [4:0] GAP_LAST   = 5'(GAP_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_EMPTY,
      S_FILL,
      S_PENDING
   } state_t;

   state_t     state_reg;
   logic       active_sel_reg;
   logic [3:0] wr_idx_reg;
   logic [4:0] gap_cnt_reg;

   logic [7:0] bank_reg [2][NCOEFF];

   // Write port decode. The first coefficient of a set always lands at index 0.
   // When a commit and a strobe coincide in S_PENDING, the strobe goes to the
   // bank that becomes the shadow after the swap, i.e. the currently active one.
   logic       wr_en;
   logic       wr_bank;
   logic [3:0] wr_addr;

   always_comb begin
      wr_en   = 1'b0;
      wr_bank = ~active_sel_reg;
      wr_addr = 4'd0;
      case (state_reg)
         S_EMPTY: begin
            wr_en = coeff_stb;
         end
         S_FILL: begin
            wr_en   = coeff_stb;
            wr_addr = wr_idx_reg;
         end
         S_PENDING: begin
            wr_en = coeff_stb;
            if (period_done_in)
               wr_bank = active_sel_reg;
         end
         default: begin
            wr_en = 1'b0;
         end
      endcase
   end

   // Control FSM with registered status outputs.
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         state_reg      <= S_EMPTY;
         active_sel_reg <= 1'b0;
         wr_idx_reg     <= 4'd0;
         gap_cnt_reg    <= 5'd0;
         set_pending    <= 1'b0;
         coeff_valid    <= 1'b0;
         commit_stb     <= 1'b0;
         set_drop       <= 1'b0;
      end else begin
         commit_stb <= 1'b0;
         set_drop   <= 1'b0;
         case (state_reg)
            S_EMPTY: begin
               if (coeff_stb) begin
                  wr_idx_reg  <= 4'd1;
                  gap_cnt_reg <= 5'd0;
                  state_reg   <= S_FILL;
               end
            end
            S_FILL: begin
               if (coeff_stb) begin
                  gap_cnt_reg <= 5'd0;
                  if (wr_idx_reg == LAST_IDX) begin
                     wr_idx_reg  <= 4'd0;
                     set_pending <= 1'b1;
                     state_reg   <= S_PENDING;
                  end else begin
                     wr_idx_reg <= wr_idx_reg + 4'd1;
                  end
               end else if (gap_cnt_reg == GAP_LAST) begin
                  // Controller stalled mid-set: discard the partial set. Shadow
                  // contents stay stale but can only be committed after a
                  // complete refill.
                  wr_idx_reg  <= 4'd0;
                  gap_cnt_reg <= 5'd0;
                  set_drop    <= 1'b1;
                  state_reg   <= S_EMPTY;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 5'd1;
               end
            end
            S_PENDING: begin
               if (period_done_in) begin
                  active_sel_reg <= ~active_sel_reg;
                  set_pending    <= 1'b0;
                  commit_stb     <= 1'b1;
                  coeff_valid    <= 1'b1;
                  if (coeff_stb) begin
                     wr_idx_reg  <= 4'd1;
                     gap_cnt_reg <= 5'd0;
                     state_reg   <= S_FILL;
                  end else begin
                     state_reg <= S_EMPTY;
                  end
               end else if (coeff_stb) begin
                  // A newer set supersedes the waiting one.
                  set_pending <= 1'b0;
                  wr_idx_reg  <= 4'd1;
                  gap_cnt_reg <= 5'd0;
                  state_reg   <= S_FILL;
               end
            end
            default: begin
               state_reg <= S_EMPTY;
            end
         endcase
      end
   end

   // Coefficient storage; both banks are cleared on reset.
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < NCOEFF; i++)
               bank_reg[b][i] <= 8'd0;
      end else if (wr_en) begin
         bank_reg[wr_bank][wr_addr] <= coeff_in;
      end
   end

   // Registered read port. Uses active_sel as it was before the edge, so the
   // new bank becomes visible one cycle after the swap.
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         coeff_rd <= 8'd0;
      end else if (coeff_addr < ADDR_LIMIT) begin
         coeff_rd <= bank_reg[active_sel_reg][coeff_addr];
      end else begin
         coeff_rd <= 8'd0;
      end
   end

endmodule

// File: tb/tb_coeff_bank.sv
// -----------------------------------------------------------------------------
// tb_coeff_bank
//
// Self-checking bench for coeff_bank. Read expectations are pushed to a queue
// when an address is driven and compared by a monitor when coeff_rd is sampled
// one cycle later. Status outputs are checked inline by each scenario task.
// -----------------------------------------------------------------------------
module tb_coeff_bank;

   logic       clk = 1'b0;
   logic       rst_an = 1'b0;
   logic [7:0] coeff_in = 8'd0;
   logic       coeff_stb = 1'b0;
   logic       period_done_in = 1'b0;
   logic [3:0] coeff_addr = 4'd0;
   logic [7:0] coeff_rd;
   logic       coeff_valid;
   logic       set_pending;
   logic       commit_stb;
   logic       set_drop;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] exp;
   } rd_t;

   rd_t  exp_q[$];
   logic rd_req = 1'b0;
   logic rd_req_s = 1'b0;

   coeff_bank #(.NCOEFF(12), .GAP_TIMEOUT(16)) dut (
      .clk            (clk),
      .rst_an         (rst_an),
      .coeff_in       (coeff_in),
      .coeff_stb      (coeff_stb),
      .period_done_in (period_done_in),
      .coeff_addr     (coeff_addr),
      .coeff_rd       (coeff_rd),
      .coeff_valid    (coeff_valid),
      .set_pending    (set_pending),
      .commit_stb     (commit_stb),
      .set_drop       (set_drop)
   );

   always #5 clk = ~clk;

   // Read monitor: a read requested before an edge is compared at the
   // following negedge.
   always @(posedge clk) rd_req_s <= rd_req;

   always @(negedge clk) begin
      if (rd_req_s) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL read_queue: got coeff_rd=%02h with no expectation queued", coeff_rd);
         end else begin
            rd_t e;
            e = exp_q.pop_front();
            if (coeff_rd !== e.exp) begin
               errors++;
               $display("FAIL read addr=%0d: got %02h expected %02h", e.addr, coeff_rd, e.exp);
            end else begin
               $display("read addr=%0d data=%02h ok", e.addr, coeff_rd);
            end
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
      rd_req = 1'b0;
   endtask

   task automatic issue_read(input logic [3:0] a, input logic [7:0] e);
      rd_t r;
      r.addr = a;
      r.exp  = e;
      coeff_addr = a;
      rd_req = 1'b1;
      exp_q.push_back(r);
   endtask

   // Back-to-back strobes of v[0..11]; optionally raise period_done_in on the
   // last strobe.
   task automatic load_set(input logic [7:0] v [12], input bit pd_on_last);
      for (int i = 0; i < 12; i++) begin
         coeff_in = v[i];
         coeff_stb = 1'b1;
         period_done_in = (pd_on_last && i == 11);
         cycle();
      end
      coeff_stb = 1'b0;
      period_done_in = 1'b0;
   endtask

   task automatic commit_and_check(input string tag);
      period_done_in = 1'b1;
      cycle();
      period_done_in = 1'b0;
      checks++;
      if (commit_stb !== 1'b1 || set_pending !== 1'b0 || coeff_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s commit: got stb=%b pend=%b valid=%b expected 1 0 1", tag, commit_stb, set_pending, coeff_valid);
      end else begin
         $display("%s commit ok", tag);
      end
      cycle();
      checks++;
      if (commit_stb !== 1'b0) begin
         errors++;
         $display("FAIL %s commit_len: got stb=%b expected 0", tag, commit_stb);
      end
   endtask

   task automatic read_all(input logic [7:0] v [12]);
      for (int i = 0; i < 12; i++) begin
         issue_read(4'(i), v[i]);
         cycle();
      end
   endtask

   task automatic test_reset();
      logic [7:0] z [12];
      rst_an = 1'b0;
      repeat (3) cycle();
      rst_an = 1'b1;
      cycle();
      checks++;
      if (coeff_rd !== 8'd0 || coeff_valid !== 1'b0 || set_pending !== 1'b0 ||
          commit_stb !== 1'b0 || set_drop !== 1'b0) begin
         errors++;
         $display("FAIL reset: got rd=%02h valid=%b pend=%b stb=%b drop=%b expected all 0",
                  coeff_rd, coeff_valid, set_pending, commit_stb, set_drop);
      end else begin
         $display("reset outputs ok");
      end
      for (int i = 0; i < 12; i++) z[i] = 8'd0;
      read_all(z);
      checks++;
      if (coeff_valid !== 1'b0 || set_pending !== 1'b0) begin
         errors++;
         $display("FAIL reset_status: got valid=%b pend=%b expected 0 0", coeff_valid, set_pending);
      end
   endtask

   task automatic test_full_set();
      logic [7:0] v [12];
      for (int i = 0; i < 12; i++) v[i] = 8'(i + 1);
      for (int i = 0; i < 12; i++) begin
         coeff_in = v[i];
         coeff_stb = 1'b1;
         cycle();
         checks++;
         if (set_pending !== (i == 11)) begin
            errors++;
            $display("FAIL full_pending strobe=%0d: got %b expected %b", i + 1, set_pending, (i == 11));
         end
      end
      coeff_stb = 1'b0;
      commit_and_check("full_set");
      issue_read(4'd5, 8'd6);   cycle();
      issue_read(4'd11, 8'd12); cycle();
      issue_read(4'd13, 8'd0);  cycle();
      read_all(v);
   endtask

   task automatic test_shadow_isolation();
      logic [7:0] old_v [12];
      logic [7:0] new_v [12];
      for (int i = 0; i < 12; i++) begin
         old_v[i] = 8'(i + 1);
         new_v[i] = 8'(-(i + 1));
      end
      // Reads run concurrently with the load and must still see the old set.
      for (int i = 0; i < 12; i++) begin
         coeff_in = new_v[i];
         coeff_stb = 1'b1;
         issue_read(4'(i), old_v[i]);
         cycle();
      end
      coeff_stb = 1'b0;
      read_all(old_v);
      commit_and_check("shadow");
      issue_read(4'd0, 8'hFF); cycle();
      read_all(new_v);
   endtask

   task automatic test_timeout();
      logic [7:0] v [12];
      for (int i = 0; i < 5; i++) begin
         coeff_in = 8'h11;
         coeff_stb = 1'b1;
         cycle();
      end
      coeff_stb = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         cycle();
         checks++;
         if (set_drop !== (k == 16)) begin
            errors++;
            $display("FAIL timeout idle=%0d: got set_drop=%b expected %b", k, set_drop, (k == 16));
         end
      end
      cycle();
      checks++;
      if (set_drop !== 1'b0 || set_pending !== 1'b0) begin
         errors++;
         $display("FAIL timeout_after: got drop=%b pend=%b expected 0 0", set_drop, set_pending);
      end else begin
         $display("timeout drop ok");
      end
      // A period pulse with nothing pending must leave the active bank alone.
      period_done_in = 1'b1;
      cycle();
      period_done_in = 1'b0;
      checks++;
      if (commit_stb !== 1'b0) begin
         errors++;
         $display("FAIL idle_period: got commit_stb=%b expected 0", commit_stb);
      end
      issue_read(4'd3, 8'hFC); cycle();
      for (int i = 0; i < 12; i++) v[i] = 8'h40;
      load_set(v, 1'b0);
      commit_and_check("after_drop");
      read_all(v);
   endtask

   task automatic test_back_to_back();
      logic [7:0] a [12];
      logic [7:0] b [12];
      logic [7:0] c [12];
      logic [7:0] d [12];
      for (int i = 0; i < 12; i++) begin
         a[i] = 8'(8'h0A + i);
         b[i] = 8'(8'h50 + i);
         c[i] = 8'(8'h60 + i);
         d[i] = 8'(8'h77 + i);
      end
      load_set(a, 1'b0);
      load_set(b, 1'b0);
      checks++;
      if (set_pending !== 1'b1) begin
         errors++;
         $display("FAIL newest_pending: got %b expected 1", set_pending);
      end
      commit_and_check("newest");
      read_all(b);

      // Period pulse coinciding with the last strobe must not commit.
      load_set(c, 1'b1);
      checks++;
      if (commit_stb !== 1'b0 || set_pending !== 1'b1) begin
         errors++;
         $display("FAIL coincident: got stb=%b pend=%b expected 0 1", commit_stb, set_pending);
      end
      cycle();
      checks++;
      if (commit_stb !== 1'b0) begin
         errors++;
         $display("FAIL coincident_late: got stb=%b expected 0", commit_stb);
      end
      read_all(b);

      // Commit and strobe together: commit wins, strobe opens the next set.
      coeff_in = d[0];
      coeff_stb = 1'b1;
      period_done_in = 1'b1;
      cycle();
      period_done_in = 1'b0;
      checks++;
      if (commit_stb !== 1'b1 || set_pending !== 1'b0) begin
         errors++;
         $display("FAIL dual: got stb=%b pend=%b expected 1 0", commit_stb, set_pending);
      end
      for (int i = 1; i < 12; i++) begin
         coeff_in = d[i];
         coeff_stb = 1'b1;
         cycle();
      end
      coeff_stb = 1'b0;
      checks++;
      if (set_pending !== 1'b1) begin
         errors++;
         $display("FAIL dual_pending: got %b expected 1", set_pending);
      end
      read_all(c);
      commit_and_check("dual");
      read_all(d);
   endtask

   task automatic test_async_reset();
      logic [7:0] v [12];
      issue_read(4'd0, 8'h77); cycle();
      for (int i = 0; i < 7; i++) begin
         coeff_in = 8'h20;
         coeff_stb = 1'b1;
         cycle();
      end
      coeff_stb = 1'b0;
      #2;
      rst_an = 1'b0;
      #1;
      checks++;
      if (coeff_rd !== 8'd0 || coeff_valid !== 1'b0 || set_pending !== 1'b0 ||
          commit_stb !== 1'b0 || set_drop !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got rd=%02h valid=%b pend=%b stb=%b drop=%b expected all 0",
                  coeff_rd, coeff_valid, set_pending, commit_stb, set_drop);
      end else begin
         $display("async reset ok");
      end
      repeat (2) cycle();
      rst_an = 1'b1;
      cycle();
      issue_read(4'd0, 8'd0); cycle();
      for (int i = 0; i < 12; i++) v[i] = 8'(i + 1);
      load_set(v, 1'b0);
      checks++;
      if (set_pending !== 1'b1 || coeff_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_load: got pend=%b valid=%b expected 1 0", set_pending, coeff_valid);
      end
      commit_and_check("post_reset");
      issue_read(4'd5, 8'd6);   cycle();
      issue_read(4'd11, 8'd12); cycle();
      issue_read(4'd13, 8'd0);  cycle();
   endtask

   initial begin
      test_reset();
      test_full_set();
      test_shadow_isolation();
      test_timeout();
      test_back_to_back();
      test_async_reset();
      repeat (2) cycle();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL read_drain: got %0d outstanding reads expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
